// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared constants and types for the RISC-V fetch front end
package riscv_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int PC_STEP = 4;
  localparam logic [31:0] INSN_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [31:0]             ins;
  } fetch_entry_t;

endpackage

// File: rtl/riscv_fetch_unit_if.sv
// rtl/riscv_fetch_unit_if.sv - instruction memory, redirect and IF/ID handshake bundle
interface riscv_fetch_unit_if
  import riscv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int DEPTH = 4
);

  logic                    imem_en;
  logic [XLEN-1:0]         imem_addr;
  logic [31:0]             imem_rdata;
  logic                    redirect;
  logic [XLEN-1:0]         redirect_pc;
  logic                    if_valid;
  logic                    if_ready;
  logic [XLEN-1:0]         if_pc;
  logic [31:0]             if_ins;
  logic [$clog2(DEPTH):0]  if_count;

  modport master (
    output imem_en, imem_addr, if_valid, if_pc, if_ins, if_count,
    input  imem_rdata, redirect, redirect_pc, if_ready
  );

  modport slave (
    input  imem_en, imem_addr, if_valid, if_pc, if_ins, if_count,
    output imem_rdata, redirect, redirect_pc, if_ready
  );

endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - synchronous FIFO with push, pop, flush and occupancy count
module fetch_queue #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign do_pop    = pop & ~empty;
  assign do_push   = push & (~full | do_pop);
  assign head_data = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      // Flush wins over any same-cycle push or pop.
      rptr  <= wptr;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= push_data;
        wptr      <= wptr + 1'b1;
      end
      if (do_pop) begin
        rptr <= rptr + 1'b1;
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n) count <= CW'(DEPTH));

endmodule

// File: rtl/riscv_fetch_unit.sv
// rtl/riscv_fetch_unit.sv - credit-controlled fetch engine with instruction queue and redirect
module riscv_fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic                clk,
  input logic                rst,
  riscv_fetch_unit_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     ins;
  } entry_t;

  logic            run;
  logic [XLEN-1:0] fetch_pc;
  logic            inflight;
  logic [XLEN-1:0] inflight_pc;
  logic [XLEN-1:0] issue_addr;
  logic [CW:0]     pending;
  logic            credit;
  logic            issue;
  logic            push;
  logic            pop;
  entry_t          push_entry;
  entry_t          head_entry;
  logic [CW-1:0]   q_count;
  logic            q_empty;
  logic            q_full;
  logic            unused_bits;

  assign unused_bits = ^{bus.redirect_pc[1:0], q_full};

  // Credit counts only registered state so a same-cycle pop never buys an extra request.
  always_comb begin
    pending    = {1'b0, q_count} + {{CW{1'b0}}, inflight};
    credit     = pending < (CW+1)'(DEPTH);
    issue      = run & (credit | bus.redirect);
    issue_addr = bus.redirect ? {bus.redirect_pc[XLEN-1:2], 2'b00} : fetch_pc;
  end

  // run holds off the first request until the edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run         <= 1'b0;
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      run      <= 1'b1;
      inflight <= issue;
      if (issue) begin
        fetch_pc    <= issue_addr + XLEN'(PC_STEP);
        inflight_pc <= issue_addr;
      end
    end
  end

  assign push           = inflight & ~bus.redirect;
  assign pop            = ~q_empty & bus.if_ready;
  assign push_entry.pc  = inflight_pc;
  assign push_entry.ins = bus.imem_rdata;

  fetch_queue #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst),
    .flush     (bus.redirect),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head_entry),
    .count     (q_count),
    .empty     (q_empty),
    .full      (q_full)
  );

  assign bus.imem_en   = issue;
  assign bus.imem_addr = issue_addr;
  assign bus.if_valid  = ~q_empty;
  assign bus.if_pc     = head_entry.pc;
  assign bus.if_ins    = head_entry.ins;
  assign bus.if_count  = q_count;

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// tb/tb_riscv_fetch_unit.sv - directed self-checking bench for riscv_fetch_unit
module tb_riscv_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;

  riscv_fetch_unit_if #(.XLEN(32), .DEPTH(4)) bus ();

  riscv_fetch_unit #(
    .XLEN     (32),
    .DEPTH    (4),
    .RESET_PC (32'h100)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  // Memory returns the bitwise inverse of the address, one cycle after the request.
  always @(posedge clk) begin
    if (bus.imem_en) bus.imem_rdata <= ~bus.imem_addr;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    bus.if_ready    = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.imem_rdata  = '0;

    repeat (2) step();
    check("rst_en",    32'(bus.imem_en),  32'd0);
    check("rst_valid", 32'(bus.if_valid), 32'd0);
    check("rst_count", 32'(bus.if_count), 32'd0);
    check("rst_pc",    bus.if_pc,         32'h0);
    check("rst_ins",   bus.if_ins,        32'h0);
    rst = 1'b1;

    step();
    check("c1_en",    32'(bus.imem_en),  32'd1);
    check("c1_addr",  bus.imem_addr,     32'h100);
    check("c1_valid", 32'(bus.if_valid), 32'd0);
    step();
    check("c2_addr",  bus.imem_addr,     32'h104);
    check("c2_valid", 32'(bus.if_valid), 32'd0);
    step();
    check("c3_valid", 32'(bus.if_valid), 32'd1);
    check("c3_pc",    bus.if_pc,         32'h100);
    check("c3_ins",   bus.if_ins,        ~32'h100);
    check("c3_count", 32'(bus.if_count), 32'd1);
    check("c3_addr",  bus.imem_addr,     32'h108);
    step();
    check("c4_pc", bus.if_pc, 32'h104);
    bus.if_ready = 1'b0;

    step();
    check("c5_count", 32'(bus.if_count), 32'd2);
    check("c5_addr",  bus.imem_addr,     32'h110);
    step();
    check("c6_count", 32'(bus.if_count), 32'd3);
    check("c6_en",    32'(bus.imem_en),  32'd0);
    step();
    check("c7_count", 32'(bus.if_count), 32'd4);
    check("c7_en",    32'(bus.imem_en),  32'd0);
    check("c7_pc",    bus.if_pc,         32'h104);
    step();
    check("c8_count", 32'(bus.if_count), 32'd4);
    bus.if_ready = 1'b1;
    step();
    check("c9_pc",   bus.if_pc,        32'h108);
    check("c9_en",   32'(bus.imem_en), 32'd1);
    check("c9_addr", bus.imem_addr,    32'h114);
    step();
    check("c10_pc",    bus.if_pc,         32'h10C);
    check("c10_count", 32'(bus.if_count), 32'd2);
    step();
    check("c11_pc", bus.if_pc, 32'h110);
    step();
    check("c12_pc",  bus.if_pc,  32'h114);
    check("c12_ins", bus.if_ins, ~32'h114);
    step();
    check("c13_pc", bus.if_pc, 32'h118);

    step();
    check("c14_pc", bus.if_pc, 32'h11C);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h200;
    #1;
    check("rd_en",   32'(bus.imem_en), 32'd1);
    check("rd_addr", bus.imem_addr,    32'h200);
    step();
    bus.redirect = 1'b0;
    #1;
    check("rd1_count", 32'(bus.if_count), 32'd0);
    check("rd1_valid", 32'(bus.if_valid), 32'd0);
    check("rd1_addr",  bus.imem_addr,     32'h204);
    step();
    check("rd2_valid", 32'(bus.if_valid), 32'd1);
    check("rd2_pc",    bus.if_pc,         32'h200);
    check("rd2_ins",   bus.if_ins,        ~32'h200);
    step();
    check("rd3_pc", bus.if_pc, 32'h204);
    bus.if_ready = 1'b0;

    repeat (4) step();
    check("full_count", 32'(bus.if_count), 32'd4);
    check("full_en",    32'(bus.imem_en),  32'd0);
    check("full_pc",    bus.if_pc,         32'h204);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h300;
    #1;
    check("r300_addr", bus.imem_addr, 32'h300);
    step();
    check("r300_count", 32'(bus.if_count), 32'd0);
    bus.redirect_pc = 32'h400;
    #1;
    check("r400_addr", bus.imem_addr, 32'h400);
    step();
    bus.redirect = 1'b0;
    #1;
    check("r400_count", 32'(bus.if_count), 32'd0);
    check("r400_valid", 32'(bus.if_valid), 32'd0);
    check("r400_next",  bus.imem_addr,     32'h404);
    step();
    check("r400_pc",  bus.if_pc,         32'h400);
    check("r400_ins", bus.if_ins,        ~32'h400);
    check("r400_cnt", 32'(bus.if_count), 32'd1);
    bus.if_ready = 1'b1;
    step();
    check("r404_pc", bus.if_pc, 32'h404);
    step();
    check("r408_pc", bus.if_pc, 32'h408);

    step();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    #1;
    check("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
    step();
    bus.redirect = 1'b0;
    #1;
    check("wrap_next", bus.imem_addr, 32'h0);
    step();
    check("wrap_pc",  bus.if_pc,  32'hFFFF_FFFC);
    check("wrap_ins", bus.if_ins, 32'h0000_0003);
    step();
    check("wrap0_pc",  bus.if_pc,  32'h0);
    check("wrap0_ins", bus.if_ins, 32'hFFFF_FFFF);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h203;
    #1;
    check("align_addr", bus.imem_addr, 32'h200);
    step();
    bus.redirect = 1'b0;
    #1;
    check("align_next", bus.imem_addr, 32'h204);
    step();
    check("align_pc", bus.if_pc, 32'h200);
    bus.if_ready = 1'b0;

    repeat (3) step();
    check("mid_count", 32'(bus.if_count), 32'd4);
    rst = 1'b0;
    #1;
    check("mid_en",    32'(bus.imem_en),  32'd0);
    check("mid_valid", 32'(bus.if_valid), 32'd0);
    check("mid_cnt0",  32'(bus.if_count), 32'd0);
    check("mid_pc",    bus.if_pc,         32'h0);
    check("mid_ins",   bus.if_ins,        32'h0);
    step();
    rst = 1'b1;
    bus.if_ready = 1'b1;
    step();
    check("rs_en",   32'(bus.imem_en), 32'd1);
    check("rs_addr", bus.imem_addr,    32'h100);
    repeat (2) step();
    check("rs_valid", 32'(bus.if_valid), 32'd1);
    check("rs_pc",    bus.if_pc,         32'h100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
